// File: rtl/wm_pkg.sv
// Shared types and constants for the keyed watermark symbol sequencer.
// The symbol map lives here so the sequencer and any future consumers agree on it.
package wm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } wm_state_e;

  localparam logic [7:0] KEY_DEFAULT = 8'h6A;
  localparam logic [7:0] LFSR_TAPS   = 8'h1D;
  localparam int         LEN_W_DEF   = 20;

  // 2'b11 is unreachable: s0 can only be set when s1 is clear.
  function automatic logic [1:0] wm_sym_map(input logic [7:0] q);
    logic s1;
    s1 = q[1] ^ q[0];
    return {s1, (s1 ? 1'b0 : q[0])};
  endfunction

endpackage

// File: rtl/wm_lfsr.sv
// 8-bit Galois LFSR (x^8+x^4+x^3+x^2+1) with seed load and single-step advance.
// Load takes priority over step; reset seeds the register with KEY_DEFAULT.
module wm_lfsr
  import wm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] seed_i,
  input  logic       step_i,
  output logic [7:0] state_o
);

  logic [7:0] state_q;
  logic [7:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (step_i) begin
      state_d = {state_q[6:0], 1'b0} ^ (state_q[7] ? LFSR_TAPS : 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= KEY_DEFAULT;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/wm_symbol_sequencer.sv
// Frame sequencer for the keyed LFSR watermark generator: FSM, index counter, symbol handshake.
// Optional `WM_ABORT_EN adds an abort_i input that returns a running frame to IDLE.
module wm_symbol_sequencer
  import wm_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [7:0]       cfg_key_i,
  input  logic [LEN_W-1:0] cfg_len_i,
`ifdef WM_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic             sym_valid_o,
  input  logic             sym_ready_i,
  output logic [1:0]       sym_data_o,
  output logic             sym_last_o,
  output logic [LEN_W-1:0] sym_idx_o
);

  wm_state_e        state_q;
  logic [7:0]       key_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic             busy_q;
  logic             done_q;
  logic             valid_q;
  logic             last_q;

  logic [LEN_W-1:0] idx_inc;
  logic [LEN_W-1:0] len_m1;
  logic             handshake;
  logic             lfsr_load;
  logic [7:0]       lfsr_seed;
  logic [7:0]       lfsr_state;
  logic             abort_hit;

  assign idx_inc   = idx_q + LEN_W'(1);
  assign len_m1    = len_q - LEN_W'(1);
  assign handshake = valid_q & sym_ready_i;
  assign lfsr_load = (state_q == LOAD);
  assign lfsr_seed = (key_q == 8'h00) ? KEY_DEFAULT : key_q;

`ifdef WM_ABORT_EN
  assign abort_hit = abort_i & ((state_q == LOAD) | (state_q == RUN));
`else
  assign abort_hit = 1'b0;
`endif

  wm_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (lfsr_load),
    .seed_i  (lfsr_seed),
    .step_i  (handshake),
    .state_o (lfsr_state)
  );

  // Outputs are registered alongside the state; abort overrides everything, including the DONE exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= KEY_DEFAULT;
      len_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            key_q <= cfg_key_i;
            len_q <= cfg_len_i;
            if (cfg_len_i != '0) begin
              state_q <= LOAD;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        LOAD: begin
          state_q <= RUN;
          idx_q   <= '0;
          valid_q <= 1'b1;
          last_q  <= (len_q == LEN_W'(1));
        end
        RUN: begin
          if (handshake) begin
            idx_q <= idx_inc;
            if (last_q) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              last_q <= (idx_inc == len_m1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      if (abort_hit) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        last_q  <= 1'b0;
        done_q  <= 1'b0;
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sym_valid_o = valid_q;
  assign sym_last_o  = last_q;
  assign sym_idx_o   = idx_q;
  assign sym_data_o  = wm_sym_map(lfsr_state);

endmodule

// File: tb/tb_wm_symbol_sequencer.sv
// Self-checking bench for wm_symbol_sequencer: table of frames plus hand-written corner sequences.
// Expected symbols come from a GF(2^8) multiply-by-x model and a symbol lookup table.
module tb_wm_symbol_sequencer;

  localparam int         LEN_W    = 20;
  localparam logic [7:0] KEY_SEED = 8'h6A;

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic [7:0]       cfg_key_i;
  logic [LEN_W-1:0] cfg_len_i;
`ifdef WM_ABORT_EN
  logic             abort_i;
`endif
  logic             busy_o;
  logic             done_o;
  logic             sym_valid_o;
  logic             sym_ready_i;
  logic [1:0]       sym_data_o;
  logic             sym_last_o;
  logic [LEN_W-1:0] sym_idx_o;

  int nChecks;
  int nFails;

  typedef struct {
    logic [7:0] key;
    int         len;
    int         readyPct;
    bit         pokeStart;
    logic [1:0] firstSym;
  } vec_t;

  wm_symbol_sequencer #(.LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .cfg_key_i   (cfg_key_i),
    .cfg_len_i   (cfg_len_i),
`ifdef WM_ABORT_EN
    .abort_i     (abort_i),
`endif
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sym_valid_o (sym_valid_o),
    .sym_ready_i (sym_ready_i),
    .sym_data_o  (sym_data_o),
    .sym_last_o  (sym_last_o),
    .sym_idx_o   (sym_idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Multiply by x modulo x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] stepModel(input logic [7:0] x);
    logic [8:0] v;
    v = {x, 1'b0};
    if (v[8]) v = v ^ 9'h11D;
    return v[7:0];
  endfunction

  function automatic logic [1:0] symOf(input logic [7:0] x);
    case (x[1:0])
      2'b00:   return 2'b00;
      2'b01:   return 2'b10;
      2'b10:   return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [7:0] key,
                               input logic [LEN_W-1:0] len, input logic rdy);
    start_i     = st;
    cfg_key_i   = key;
    cfg_len_i   = len;
    sym_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    start_i     = 1'b0;
    sym_ready_i = 1'b0;
`ifdef WM_ABORT_EN
    abort_i     = 1'b0;
`endif
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Busy"},  busy_o, 0);
    checkOutput({tag, "Done"},  done_o, 0);
    checkOutput({tag, "Valid"}, sym_valid_o, 0);
    checkOutput({tag, "Last"},  sym_last_o, 0);
    checkOutput({tag, "Idx"},   sym_idx_o, 0);
    checkOutput({tag, "Data"},  sym_data_o, symOf(KEY_SEED));
  endtask

  task automatic runFrame(input logic [7:0] key, input int len, input int readyPct,
                          input bit pokeStart, input logic [1:0] expFirst);
    logic [1:0] expSym[$];
    logic [7:0] s;
    logic       rdy;
    logic       st;
    logic       vBefore;
    int         hs;
    int         cyc;
    s = (key == 8'h00) ? KEY_SEED : key;
    for (int i = 0; i < len; i++) begin
      expSym.push_back(symOf(s));
      s = stepModel(s);
    end
    applyStimulus(1'b1, key, LEN_W'(len), 1'b0);
    checkOutput("loadBusy", busy_o, 1);
    checkOutput("loadValid", sym_valid_o, 0);
    applyStimulus(1'b0, key, LEN_W'(len), 1'b0);
    checkOutput("firstValid", sym_valid_o, 1);
    checkOutput("firstSym", sym_data_o, expFirst);
    hs  = 0;
    cyc = 0;
    while (hs < len && cyc < len * 40 + 20) begin
      checkOutput("runValid", sym_valid_o, 1);
      checkOutput("runData", sym_data_o, expSym[hs]);
      checkOutput("runIdx", sym_idx_o, hs);
      checkOutput("runLast", sym_last_o, (hs == len - 1));
      checkOutput("runBusy", busy_o, 1);
      checkOutput("runDone", done_o, 0);
      checkOutput("no11", (sym_data_o == 2'b11), 0);
      rdy     = ($urandom_range(99) < readyPct);
      st      = pokeStart ? 1'($urandom_range(1)) : 1'b0;
      vBefore = sym_valid_o;
      applyStimulus(st, 8'($urandom), LEN_W'($urandom_range(50)), rdy);
      if (rdy && vBefore) hs++;
      cyc++;
    end
    if (hs < len) begin
      checkOutput("frameTimeout", hs, len);
      resetDut();
      return;
    end
    checkOutput("doneHigh", done_o, 1);
    checkOutput("doneValid", sym_valid_o, 0);
    checkOutput("doneBusy", busy_o, 0);
    checkOutput("doneLast", sym_last_o, 0);
    applyStimulus(1'b0, key, LEN_W'(len), 1'b0);
    checkOutput("doneOnce", done_o, 0);
    checkOutput("idleValid", sym_valid_o, 0);
    checkOutput("idleBusy", busy_o, 0);
    applyStimulus(1'b0, key, LEN_W'(len), 1'b0);
    checkOutput("noRestart", sym_valid_o | busy_o, 0);
  endtask

  // Runs a frame with ready high until index 5 is on the bus; returns with that cycle's inputs pending.
  task automatic advanceToIdx5(input logic [7:0] key);
    int cyc;
    applyStimulus(1'b1, key, LEN_W'(10), 1'b0);
    applyStimulus(1'b0, key, LEN_W'(10), 1'b1);
    cyc = 0;
    while (!(sym_valid_o && sym_idx_o == LEN_W'(5)) && cyc < 30) begin
      applyStimulus(1'b0, key, LEN_W'(10), 1'b1);
      cyc++;
    end
    checkOutput("reachIdx5", sym_idx_o, 5);
  endtask

  vec_t vecs[6];

  initial begin
    nChecks = 0;
    nFails  = 0;
    vecs[0] = '{key: 8'h6A, len: 3,   readyPct: 100, pokeStart: 1'b0, firstSym: 2'b10};
    vecs[1] = '{key: 8'h00, len: 1,   readyPct: 100, pokeStart: 1'b0, firstSym: 2'b10};
    vecs[2] = '{key: 8'h01, len: 256, readyPct: 100, pokeStart: 1'b0, firstSym: 2'b10};
    vecs[3] = '{key: 8'h6A, len: 10,  readyPct: 50,  pokeStart: 1'b0, firstSym: 2'b10};
    vecs[4] = '{key: 8'h03, len: 10,  readyPct: 100, pokeStart: 1'b0, firstSym: 2'b01};
    vecs[5] = '{key: 8'hD4, len: 6,   readyPct: 70,  pokeStart: 1'b1, firstSym: 2'b00};

    start_i     = 1'b0;
    cfg_key_i   = 8'h00;
    cfg_len_i   = '0;
    sym_ready_i = 1'b0;
`ifdef WM_ABORT_EN
    abort_i     = 1'b0;
`endif
    rst_n = 1'b0;
    #23;
    checkResetValues("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      runFrame(vecs[i].key, vecs[i].len, vecs[i].readyPct, vecs[i].pokeStart, vecs[i].firstSym);
    end

    for (int i = 0; i < 6; i++) begin
      logic [7:0] k;
      k = 8'($urandom);
      runFrame(k, 1 + $urandom_range(39), 50, 1'b1, symOf((k == 8'h00) ? KEY_SEED : k));
    end

    // Zero-length frame: done the very next cycle, never busy or valid.
    applyStimulus(1'b1, 8'h11, '0, 1'b1);
    checkOutput("len0Done", done_o, 1);
    checkOutput("len0Busy", busy_o, 0);
    checkOutput("len0Valid", sym_valid_o, 0);
    applyStimulus(1'b0, 8'h11, '0, 1'b1);
    checkOutput("len0DoneOnce", done_o, 0);
    checkOutput("len0Valid2", sym_valid_o, 0);

    // Asynchronous reset in the middle of a frame.
    advanceToIdx5(8'h5C);
    rst_n = 1'b0;
    #1;
    checkResetValues("midRst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h00, '0, 1'b1);
      checkOutput("midRstNoDone", done_o, 0);
      checkOutput("midRstIdle", sym_valid_o, 0);
    end

`ifdef WM_ABORT_EN
    advanceToIdx5(8'h5C);
    abort_i = 1'b1;
    applyStimulus(1'b0, 8'h5C, LEN_W'(10), 1'b1);
    abort_i = 1'b0;
    checkOutput("abortValid", sym_valid_o, 0);
    checkOutput("abortBusy", busy_o, 0);
    checkOutput("abortDone", done_o, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h5C, LEN_W'(10), 1'b1);
      checkOutput("abortNoDone", done_o, 0);
      checkOutput("abortIdle", sym_valid_o, 0);
    end
    runFrame(8'h6A, 3, 100, 1'b0, 2'b10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/wm_symbol_sequencer.md
# wm_symbol_sequencer

Controller that sequences the keyed 8-bit LFSR watermark symbol generator for one image frame. On `start` it loads a key, then emits a fixed number of 2-bit watermark symbols to the downstream embedder over a valid/ready handshake. The LFSR advances only on an accepted symbol. It sits between frame-level control and the pixel embedder.

## Interface
- `KEY_DEFAULT`, 8'h6A: reset seed; also replaces an all-zero `cfg_key`.
- `LEN_W`, 20: width of the symbol-count and index fields.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame-start pulse; sampled only in IDLE.
- `cfg_key`  in  8  seed; captured on accepted `start`.
- `cfg_len`  in  LEN_W  symbols per frame; captured on accepted `start`.
- `busy`  out  1  high in LOAD and RUN.
- `done`  out  1  one-cycle pulse after the final symbol is accepted.
- `sym_valid`  out  1  symbol available.
- `sym_ready`  in  1  embedder accepts the symbol.
- `sym_data`  out  2  watermark symbol.
- `sym_last`  out  1  marks the final symbol of the frame; qualified by `sym_valid`.
- `sym_idx`  out  LEN_W  index of the current symbol, 0-based.

## Operation
- LFSR: Galois, polynomial x^8+x^4+x^3+x^2+1 (tap mask 8'h1D), period 255. Feedback f = Q[7]. Next state = {Q[6:4], Q[3]^f, Q[2]^f, Q[1]^f, Q[0], f}.
- Symbol map from the current state: s1 = Q[1]^Q[0]; s0 = s1 ? 0 : Q[0]. The value 2'b11 is never produced.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE, `start`=1, `cfg_len`≠0 → LOAD. Key and length are captured in this cycle.
  - IDLE, `start`=1, `cfg_len`=0 → DONE. No symbols are emitted.
  - LOAD → RUN unconditionally. The LFSR is loaded with the key, or with `KEY_DEFAULT` if the key is 0. `sym_idx` is cleared.
  - RUN: `sym_valid`=1. On handshake (`sym_valid`&`sym_ready`) the LFSR steps once and `sym_idx` increments. A handshake with `sym_idx`=len-1 → DONE.
  - DONE → IDLE. `done`=1 for exactly this cycle.
- `start` outside IDLE is ignored. It is not queued.
- `sym_last` = (`sym_idx` == len-1) while in RUN.
- `sym_data`, `sym_last` and `sym_idx` are held stable while `sym_valid`=1 and `sym_ready`=0.
- `sym_idx` wraps never: the length bounds it. The LFSR wraps naturally after 255 steps.

## Timing
- Reset values: FSM=IDLE, LFSR=`KEY_DEFAULT`, `busy`=0, `done`=0, `sym_valid`=0, `sym_last`=0, `sym_idx`=0, `sym_data`=map(`KEY_DEFAULT`).
- `start` is accepted at cycle t. LOAD occurs at t+1. The first `sym_valid` occurs at t+2 and carries the symbol of the seed state.
- Throughput: one symbol per cycle when `sym_ready` is held high.
- Final handshake at cycle n → `done`=1 at n+1. At n+1 `sym_valid`=0 and `busy`=0. A new `start` is accepted at n+2.
- `cfg_len`=0: `start` at t → `done` at t+1. `busy` stays 0.
- Reset asserted mid-frame: all outputs go to their reset values immediately. No `done` is generated.

## Configuration
- Macro: `WM_ABORT_EN`.
- Defined: adds input `abort` (1 bit).
  - `abort`=1 in LOAD or RUN → IDLE on the next edge. `sym_valid` drops, no `done` is generated, and the LFSR is left as-is.
  - A handshake in the same cycle as `abort` is still counted. Abort wins over the → DONE transition.
  - In IDLE and DONE, `abort` is ignored.
- Undefined: the port is absent. A frame always runs to completion or reset.

## Structure
- Package `wm_pkg` holds:
  - the FSM state enum;
  - the `KEY_DEFAULT` constant;
  - the LFSR tap mask 8'h1D;
  - a function mapping 8-bit state to a 2-bit symbol.
- Sub-module `wm_lfsr` has ports `clk`, `rst_n`, `load`, `seed[7:0]`, `step` and `state[7:0]`. `load` has priority over `step`.
- The sequencer holds the FSM, the length/index counter and the output registers.

## Test plan
- Reset, then key 8'h6A, len 3, `sym_ready`=1 → symbols 10, 00, 10 (states 6A, D4, B5). `sym_last` is set on idx 2. `done` occurs 1 cycle after the 3rd handshake.
- Key 8'h00, len 1 → seed is 8'h6A and the only symbol is 2'b10.
- Len 256, key 8'h01 → symbol at idx 255 equals the symbol at idx 0. 2'b11 never appears.
- `sym_ready` toggled randomly (50%), len 10 → exactly 10 handshakes. Outputs stay stable while stalled. The sequence is identical to the no-stall run.
- Len 0 → `done` at t+1 with `sym_valid` never high. A `start` during RUN is ignored and produces no restart.
- Reset asserted at idx 5 of len 10 → outputs reset immediately and no `done` occurs. With `WM_ABORT_EN`, `abort` at idx 5 → IDLE next cycle, `sym_valid`=0, no `done`.
